// File: rtl/sa_pkg.sv
// ============================================================================
// Module   : sa_pkg
// Purpose  : Shared widths, FSM encoding and drain-length helper for sa_feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sa_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PSUM_WIDTH_DEF = 32;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_preload = 3'd1;
  localparam logic [2:0] c_st_stream  = 3'd2;
  localparam logic [2:0] c_st_drain   = 3'd3;
  localparam logic [2:0] c_st_done    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = c_st_idle,
    ST_PRELOAD = c_st_preload,
    ST_STREAM  = c_st_stream,
    ST_DRAIN   = c_st_drain,
    ST_DONE    = c_st_done
  } state_t;

  // Skew flush plus psum propagation through the array.
  function automatic int drain_len(input int pe_size);
    return 2 * pe_size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sa_skew_line.sv
// ============================================================================
// Module   : sa_skew_line
// Purpose  : DEPTH-stage {en,data} delay line; a stage's data only loads when
//            the enable arriving with it is set, so the output holds on bubbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  en_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DEPTH-1:0]      r_en;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_en[0] <= en_i;
      if (en_i) begin
        r_data[0] <= data_i;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_en[i] <= r_en[i-1];
        if (r_en[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign en_o   = r_en[DEPTH-1];
  assign data_o = r_data[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sa_feeder.sv
// ============================================================================
// Module   : sa_feeder
// Purpose  : Two-phase systolic-array sequencer: ifmap row preload, then
//            diagonally skewed weight streaming with zero psum injection.
//            Optional macro SA_FEEDER_STALL_CNT_EN adds stall_cnt_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_feeder
  import sa_pkg::*;
#(
  parameter int PE_SIZE    = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int KLEN_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [KLEN_WIDTH-1:0]         k_len_i,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] ifmap_data_i,
  input  logic                          ifmap_valid_i,
  output logic                          ifmap_ready_o,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] weight_data_i,
  input  logic                          weight_valid_i,
  output logic                          weight_ready_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0] ifmap_row_o,
  output logic [PE_SIZE-1:0]            ifmap_en_row_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0] weight_col_o,
  output logic [PE_SIZE-1:0]            weight_en_col_o,
  output logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_o,
  output logic [PE_SIZE-1:0]            psum_en_row_o,
  output logic                          busy_o,
  output logic                          done_o
`ifdef SA_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt_o
`endif
);

  localparam int ROW_W   = $clog2(PE_SIZE + 1);
  localparam int DRAIN_W = $clog2(drain_len(PE_SIZE) + 1);
  localparam logic [ROW_W-1:0]   c_row_last   = ROW_W'(PE_SIZE - 1);
  localparam logic [DRAIN_W-1:0] c_drain_last = DRAIN_W'(drain_len(PE_SIZE) - 1);

  state_t                r_state;
  logic [KLEN_WIDTH-1:0] r_k_len;
  logic [KLEN_WIDTH-1:0] r_col_cnt;
  logic [ROW_W-1:0]      r_row_cnt;
  logic [DRAIN_W-1:0]    r_drain_cnt;

  logic                  w_ifmap_hs;
  logic                  w_weight_hs;
  logic [KLEN_WIDTH-1:0] w_col_next;

  assign w_ifmap_hs  = ifmap_valid_i & ifmap_ready_o;
  assign w_weight_hs = weight_valid_i & weight_ready_o;
  // Never reaches 2^KLEN_WIDTH: the last column is caught at col_cnt == k_len-1.
  assign w_col_next  = r_col_cnt + 1'b1;

`ifdef SA_FEEDER_STALL_CNT_EN
  logic w_stall;
  assign w_stall = ((r_state == ST_PRELOAD) && ifmap_ready_o && !ifmap_valid_i) ||
                   ((r_state == ST_STREAM) && weight_ready_o && !weight_valid_i);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_k_len        <= '0;
      r_col_cnt      <= '0;
      r_row_cnt      <= '0;
      r_drain_cnt    <= '0;
      ifmap_ready_o  <= 1'b0;
      weight_ready_o <= 1'b0;
      ifmap_row_o    <= '0;
      ifmap_en_row_o <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
`ifdef SA_FEEDER_STALL_CNT_EN
      stall_cnt_o    <= '0;
`endif
    end else begin
      done_o         <= 1'b0;
      ifmap_en_row_o <= '0;

      unique case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_k_len     <= k_len_i;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_drain_cnt <= '0;
            busy_o      <= 1'b1;
            if (k_len_i != '0) begin
              r_state       <= ST_PRELOAD;
              ifmap_ready_o <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              done_o  <= 1'b1;
            end
          end
        end

        ST_PRELOAD: begin
          if (w_ifmap_hs) begin
            ifmap_row_o    <= ifmap_data_i;
            ifmap_en_row_o <= '1;
            if (r_row_cnt == c_row_last) begin
              r_state        <= ST_STREAM;
              ifmap_ready_o  <= 1'b0;
              weight_ready_o <= 1'b1;
              r_col_cnt      <= '0;
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
          end
        end

        ST_STREAM: begin
          if (w_weight_hs) begin
            r_col_cnt <= w_col_next;
            if (w_col_next == r_k_len) begin
              r_state        <= ST_DRAIN;
              weight_ready_o <= 1'b0;
              r_drain_cnt    <= '0;
            end
          end
        end

        ST_DRAIN: begin
          if (r_drain_cnt == c_drain_last) begin
            r_state <= ST_DONE;
            done_o  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          busy_o  <= 1'b0;
        end

        default: begin
          r_state        <= ST_IDLE;
          busy_o         <= 1'b0;
          ifmap_ready_o  <= 1'b0;
          weight_ready_o <= 1'b0;
        end
      endcase

`ifdef SA_FEEDER_STALL_CNT_EN
      if ((r_state == ST_IDLE) && start_i) begin
        stall_cnt_o <= '0;
      end else if (w_stall && (stall_cnt_o != 16'hFFFF)) begin
        stall_cnt_o <= stall_cnt_o + 16'd1;
      end
`endif
    end
  end

  // Lane j sits j+1 registers deep so column data enters the array diagonally.
  for (genvar j = 0; j < PE_SIZE; j++) begin : g_lane
    sa_skew_line #(
      .DEPTH      (j + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (w_weight_hs),
      .data_i (weight_data_i[j*DATA_WIDTH +: DATA_WIDTH]),
      .en_o   (weight_en_col_o[j]),
      .data_o (weight_col_o[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign psum_en_row_o = weight_en_col_o;
  assign psum_row_o    = '0;

endmodule

`default_nettype wire

// File: tb/tb_sa_feeder.sv
// ============================================================================
// Module   : tb_sa_feeder
// Purpose  : Self-checking bench for sa_feeder against a handshake-schedule
//            reference model (directed and randomized passes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_feeder;

  localparam int PE = 2;
  localparam int DW = 8;
  localparam int PW = 32;
  localparam int KW = 8;
  localparam int N  = 2400;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start_i = 1'b0;
  logic [KW-1:0]        k_len_i = '0;
  logic [PE*DW-1:0]     ifmap_data_i = '0;
  logic                 ifmap_valid_i = 1'b0;
  logic                 ifmap_ready_o;
  logic [PE*DW-1:0]     weight_data_i = '0;
  logic                 weight_valid_i = 1'b0;
  logic                 weight_ready_o;
  logic [PE*DW-1:0]     ifmap_row_o;
  logic [PE-1:0]        ifmap_en_row_o;
  logic [PE*DW-1:0]     weight_col_o;
  logic [PE-1:0]        weight_en_col_o;
  logic [PW*PE-1:0]     psum_row_o;
  logic [PE-1:0]        psum_en_row_o;
  logic                 busy_o;
  logic                 done_o;
`ifdef SA_FEEDER_STALL_CNT_EN
  logic [15:0]          stall_cnt_o;
`endif

  always #5 clk = ~clk;

  sa_feeder #(
    .PE_SIZE    (PE),
    .DATA_WIDTH (DW),
    .PSUM_WIDTH (PW),
    .KLEN_WIDTH (KW)
  ) dut (
`ifdef SA_FEEDER_STALL_CNT_EN
    .stall_cnt_o     (stall_cnt_o),
`endif
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .k_len_i         (k_len_i),
    .ifmap_data_i    (ifmap_data_i),
    .ifmap_valid_i   (ifmap_valid_i),
    .ifmap_ready_o   (ifmap_ready_o),
    .weight_data_i   (weight_data_i),
    .weight_valid_i  (weight_valid_i),
    .weight_ready_o  (weight_ready_o),
    .ifmap_row_o     (ifmap_row_o),
    .ifmap_en_row_o  (ifmap_en_row_o),
    .weight_col_o    (weight_col_o),
    .weight_en_col_o (weight_en_col_o),
    .psum_row_o      (psum_row_o),
    .psum_en_row_o   (psum_en_row_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Per-edge stimulus of the current pass; edge 0 is the start edge.
  bit               iv [N];
  bit               wv [N];
  bit               sv [N];
  logic [PE*DW-1:0] id [N];
  logic [PE*DW-1:0] wd [N];
  logic [KW-1:0]    ks [N];

  // Reference schedule: which edges transfer, and the phase boundaries.
  bit ihs [N];
  bit whs [N];
  int p_end, q_end, d_cyc;

  // Values the SA-side outputs are expected to be holding.
  logic [PE*DW-1:0] m_row;
  logic [DW-1:0]    m_lane [PE];
  int               m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int pct, input bit rnd);
    for (int e = 0; e < N; e++) begin
      iv[e] = rnd && (($urandom_range(99) >= pct) || e >= 2000);
      wv[e] = rnd && (($urandom_range(99) >= pct) || e >= 2000);
      sv[e] = rnd && ($urandom_range(3) == 0);
      id[e] = rnd ? (PE*DW)'($urandom) : '0;
      wd[e] = rnd ? (PE*DW)'($urandom) : '0;
      ks[e] = rnd ? KW'($urandom) : '0;
    end
  endtask

  // PE_SIZE ifmap transfers while preloading, then k weight transfers,
  // then 2*PE_SIZE drain cycles and the done cycle.
  task automatic sched(input int k);
    int cnt;
    for (int e = 0; e < N; e++) begin
      ihs[e] = 1'b0;
      whs[e] = 1'b0;
    end
    p_end = 0;
    q_end = 0;
    d_cyc = 0;
    if (k != 0) begin
      cnt = 0;
      for (int e = 1; e < N && cnt < PE; e++) begin
        if (iv[e]) begin
          ihs[e] = 1'b1;
          cnt++;
          p_end = e;
        end
      end
      cnt = 0;
      for (int e = p_end + 1; e < N && cnt < k; e++) begin
        if (wv[e]) begin
          whs[e] = 1'b1;
          cnt++;
          q_end = e;
        end
      end
      d_cyc = q_end + 2 * PE;
    end
  endtask

  task automatic drive(input int e);
    @(negedge clk);
    start_i        = sv[e];
    k_len_i        = ks[e];
    ifmap_valid_i  = iv[e];
    ifmap_data_i   = id[e];
    weight_valid_i = wv[e];
    weight_data_i  = wd[e];
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input int c, input int k);
    logic [PE-1:0]    exp_en;
    logic [PE*DW-1:0] exp_col;
    bit               in_pre, in_str;
    in_pre = (k != 0) && (c < p_end);
    in_str = (k != 0) && (c >= p_end) && (c < q_end);
    if (ihs[c]) m_row = id[c];
    for (int j = 0; j < PE; j++) begin
      exp_en[j] = 1'b0;
      if ((c - j >= 1) && whs[c-j]) begin
        m_lane[j] = wd[c-j][j*DW +: DW];
        exp_en[j] = 1'b1;
      end
      exp_col[j*DW +: DW] = m_lane[j];
    end
    chk("ifmap_ready",  64'(ifmap_ready_o),   64'(in_pre));
    chk("weight_ready", 64'(weight_ready_o),  64'(in_str));
    chk("ifmap_en",     64'(ifmap_en_row_o),  ihs[c] ? 64'({PE{1'b1}}) : 64'd0);
    chk("ifmap_row",    64'(ifmap_row_o),     64'(m_row));
    chk("weight_en",    64'(weight_en_col_o), 64'(exp_en));
    chk("weight_col",   64'(weight_col_o),    64'(exp_col));
    chk("psum_en",      64'(psum_en_row_o),   64'(exp_en));
    chk("psum_row",     64'(psum_row_o),      64'd0);
    chk("busy",         64'(busy_o),          64'(c <= d_cyc));
    chk("done",         64'(done_o),          64'(c == d_cyc));
`ifdef SA_FEEDER_STALL_CNT_EN
    chk("stall_cnt",    64'(stall_cnt_o),     64'(m_stall));
    if (((in_pre && !iv[c+1]) || (in_str && !wv[c+1])) && m_stall < 16'hFFFF) m_stall++;
`endif
  endtask

  task automatic run_pass(input int k);
    sv[0]   = 1'b1;
    ks[0]   = KW'(k);
    m_stall = 0;
    sched(k);
    for (int c = 0; c <= d_cyc + 1; c++) begin
      drive(c);
      check_cycle(c, k);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},    64'(busy_o),          64'd0);
    chk({tag, "_done"},    64'(done_o),          64'd0);
    chk({tag, "_readys"},  64'({ifmap_ready_o, weight_ready_o}), 64'd0);
    chk({tag, "_ien"},     64'(ifmap_en_row_o),  64'd0);
    chk({tag, "_irow"},    64'(ifmap_row_o),     64'd0);
    chk({tag, "_wen"},     64'(weight_en_col_o), 64'd0);
    chk({tag, "_wcol"},    64'(weight_col_o),    64'd0);
    chk({tag, "_penpsum"}, 64'({psum_en_row_o, psum_row_o}), 64'd0);
`ifdef SA_FEEDER_STALL_CNT_EN
    chk({tag, "_stall"},   64'(stall_cnt_o),     64'd0);
`endif
  endtask

  task automatic model_reset();
    m_row   = '0;
    m_stall = 0;
    for (int j = 0; j < PE; j++) m_lane[j] = '0;
  endtask

  initial begin
    model_reset();

    // Reset state, then one idle cycle after release.
    @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("post_reset");

    // Nominal: k=3, rows back-to-back, columns back-to-back from edge 3.
    fill(0, 1'b0);
    iv[1] = 1'b1; id[1] = 16'h0204;
    iv[2] = 1'b1; id[2] = 16'h0103;
    wv[3] = 1'b1; wd[3] = 16'h0100;
    wv[4] = 1'b1; wd[4] = 16'h0203;
    wv[5] = 1'b1; wd[5] = 16'h0004;
    run_pass(3);

    // One-cycle bubble after the first column.
    fill(0, 1'b0);
    iv[1] = 1'b1; id[1] = 16'h0204;
    iv[2] = 1'b1; id[2] = 16'h0103;
    wv[3] = 1'b1; wd[3] = 16'h0100;
    wv[5] = 1'b1; wd[5] = 16'h0203;
    wv[6] = 1'b1; wd[6] = 16'h0004;
    run_pass(3);

    // Zero length, with random start/k_len noise while busy.
    fill(30, 1'b1);
    run_pass(0);

    // Randomized passes back-to-back; extra starts and k_len changes are noise.
    for (int r = 0; r < 8; r++) begin
      fill(10 * (r % 5), 1'b1);
      run_pass(1 + int'($urandom_range(11)));
    end

    // Longest column count.
    fill(10, 1'b1);
    run_pass((1 << KW) - 1);

    // Asynchronous reset in the middle of streaming.
    fill(20, 1'b1);
    sv[0] = 1'b1;
    ks[0] = KW'(6);
    m_stall = 0;
    sched(6);
    for (int c = 0; c <= p_end + 2; c++) begin
      drive(c);
      check_cycle(c, 6);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_idle("mid_reset");
    @(negedge clk);
    start_i        = 1'b0;
    ifmap_valid_i  = 1'b0;
    weight_valid_i = 1'b0;
    rst_n          = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("after_mid_reset");

    // A full pass still works after the abort.
    fill(15, 1'b1);
    run_pass(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
